// File: rtl/reg_cmd_master.sv
// -----------------------------------------------------------------------------
// reg_cmd_master
//
// Command-queue bus master for the register-control block. Host commands
// (read or write) are accepted on a valid/ready port and buffered in a small
// FIFO. Each command is then issued as a single sel/wr/addr/wdata transfer,
// honouring the register block's ready handshake. Read data is captured one
// cycle after the read is accepted and returned on a valid/ready response port.
// Only one transfer is outstanding at a time, and no new command is issued
// while a response is still pending.
//
// Parameters:
//   ADDR_WIDTH     register address width
//   DATA_WIDTH     register data width
//   CMD_DEPTH      command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES REQ watchdog limit (used only with the macro below)
//
// Optional feature macro:
//   REG_CMD_MASTER_TIMEOUT_EN  when defined, a transfer stalled in REQ for
//                              TIMEOUT_CYCLES cycles is abandoned and answered
//                              with rsp_err = 1. When undefined, REQ waits
//                              forever and rsp_err is tied to 0.
//
// Ports:
//   clk, rstn                        clock, synchronous active-low reset
//   cmd_valid/cmd_ready              host command handshake
//   cmd_wr/cmd_addr/cmd_wdata        command payload
//   sel/wr/addr/wdata                transfer request to the register block
//   ready/rdata                      register block handshake and read data
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata/rsp_err                response payload
//   busy                             FIFO non-empty or FSM not IDLE
// -----------------------------------------------------------------------------
module reg_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  // host command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // register block port
  output logic                  sel,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  // host response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int PTR_W   = $clog2(CMD_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  // Elaboration-time guards on illegal configurations.
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("reg_cmd_master: CMD_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reg_cmd_master: TIMEOUT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [1:0]         state;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != CNT_W'(CMD_DEPTH));
  assign push       = cmd_valid & cmd_ready;
  // The head is taken only when the FSM is idle and no response is owed.
  assign pop        = (state == ST_IDLE) & ~fifo_empty & ~rsp_valid;
  assign head       = fifo_mem[rd_ptr];
  assign busy       = ~fifo_empty | (state != ST_IDLE);

  // NOTE: the FIFO storage is deliberately not reset; an entry is only ever
  // read after it has been written, and leaving it out of reset keeps it a
  // plain RAM-style array.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and the
  // sensitivity list carries only clk.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so they wrap modulo CMD_DEPTH for free.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or push and pop together: occupancy unchanged
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
`ifdef REG_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            rsp_err_q;

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      sel       <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef REG_CMD_MASTER_TIMEOUT_EN
      rsp_err_q <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {wr, addr, wdata} <= head;
            sel               <= 1'b1;
            state             <= ST_REQ;
`ifdef REG_CMD_MASTER_TIMEOUT_EN
            to_cnt            <= '0;
`endif
          end
        end

        ST_REQ: begin
          // sel is always high here, so ready alone marks acceptance.
          if (ready) begin
            sel   <= 1'b0;
            state <= wr ? ST_IDLE : ST_RDATA;
          end
`ifdef REG_CMD_MASTER_TIMEOUT_EN
          // to_cnt counts completed stall edges; the edge that would make it
          // reach TIMEOUT_CYCLES abandons the transfer instead.
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            sel       <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err_q <= 1'b1;
            rsp_rdata <= '0;
            state     <= ST_RSP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        ST_RDATA: begin
          // The register block presents read data one cycle after acceptance.
          rsp_rdata <= rdata;
          rsp_valid <= 1'b1;
`ifdef REG_CMD_MASTER_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          state     <= ST_RSP;
        end

        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_reg_cmd_master
//
// Directed testbench for reg_cmd_master. A small register-file stub plays the
// register block: it stores accepted writes and returns registered read data
// one cycle after an accepted read. Each scenario task drives stimulus and
// compares DUT outputs against hand-computed values, sampled 1 time unit
// after the rising edge. The timeout scenario is built only when
// REG_CMD_MASTER_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 8).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_cmd_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        sel;
  logic        wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  reg_cmd_master #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (16),
    .CMD_DEPTH     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .sel       (sel),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Register block stub: registered read data, writes stored on acceptance.
  logic [15:0] regs [256];
  initial rdata = 16'h0000;
  always @(posedge clk) begin
    if (sel && ready) begin
      if (wr) regs[addr] <= wdata;
      else    rdata      <= regs[addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    checks++; if (sel !== 1'b0)          begin errors++; $display("FAIL reset_sel: got %b want 0", sel); end
    checks++; if (wr !== 1'b0)           begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
    checks++; if (addr !== 8'h00)        begin errors++; $display("FAIL reset_addr: got %h want 00", addr); end
    checks++; if (wdata !== 16'h0000)    begin errors++; $display("FAIL reset_wdata: got %h want 0000", wdata); end
    checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0)      begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1)    begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    rstn = 1'b1;
    step();
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  // Write 0x05 <- 0xBEEF, then read it back with ready held high.
  task automatic test_write_read();
    ready     = 1'b1;
    rsp_ready = 1'b0;
    push(1'b1, 8'h05, 16'hBEEF);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_after_push: got %b want 1", busy); end
    checks++; if (sel !== 1'b0)  begin errors++; $display("FAIL wr_sel_same_edge: got %b want 0", sel); end
    step();
    checks++; if (sel !== 1'b1)       begin errors++; $display("FAIL wr_sel: got %b want 1", sel); end
    checks++; if (wr !== 1'b1)        begin errors++; $display("FAIL wr_wr: got %b want 1", wr); end
    checks++; if (addr !== 8'h05)     begin errors++; $display("FAIL wr_addr: got %h want 05", addr); end
    checks++; if (wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_wdata: got %h want beef", wdata); end
    step();
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL wr_accept_sel: got %b want 0", sel); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %b want 0", rsp_valid); end

    push(1'b0, 8'h05, 16'h0000);
    step();
    checks++; if (sel !== 1'b1)   begin errors++; $display("FAIL rd_sel: got %b want 1", sel); end
    checks++; if (wr !== 1'b0)    begin errors++; $display("FAIL rd_wr: got %b want 0", wr); end
    checks++; if (addr !== 8'h05) begin errors++; $display("FAIL rd_addr: got %h want 05", addr); end
    step();
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL rd_accept_sel: got %b want 0", sel); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_early: got %b want 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1)     begin errors++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h want beef", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0)       begin errors++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_rsp_clear: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rd_busy_end: got %b want 0", busy); end
  endtask

  // One command stalled in REQ plus four queued fills the FIFO; releasing
  // ready drains them in order.
  task automatic test_fifo_full();
    ready     = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
      cmd_addr  = 8'h20 + 8'(i);
      cmd_wdata = 16'h1000 + 16'(i);
      step();
      checks++;
      if (cmd_ready !== (i != 4)) begin
        errors++; $display("FAIL fifo_cmd_ready_push%0d: got %b want %b", i, cmd_ready, (i != 4));
      end
    end
    cmd_valid = 1'b0;
    checks++; if (sel !== 1'b1)   begin errors++; $display("FAIL fifo_head_sel: got %b want 1", sel); end
    checks++; if (addr !== 8'h20) begin errors++; $display("FAIL fifo_head_addr: got %h want 20", addr); end
    ready = 1'b1;
    step();
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL fifo_first_accept_sel: got %b want 0", sel); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_still_full: got %b want 0", cmd_ready); end
    for (int k = 1; k < 5; k++) begin
      step();
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL fifo_issue%0d_sel: got %b want 1", k, sel); end
      checks++;
      if (addr !== 8'h20 + 8'(k)) begin
        errors++; $display("FAIL fifo_issue%0d_addr: got %h want %h", k, addr, 8'h20 + 8'(k));
      end
      checks++;
      if (wdata !== 16'h1000 + 16'(k)) begin
        errors++; $display("FAIL fifo_issue%0d_wdata: got %h want %h", k, wdata, 16'h1000 + 16'(k));
      end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fifo_issue%0d_cmd_ready: got %b want 1", k, cmd_ready); end
      step();
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL fifo_gap%0d_sel: got %b want 0", k, sel); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifo_drained_busy: got %b want 0", busy); end
  endtask

  // A pending read response blocks the queued write until the handshake.
  task automatic test_rsp_backpressure();
    ready     = 1'b1;
    rsp_ready = 1'b0;
    push(1'b0, 8'h05, 16'h0000);
    push(1'b1, 8'h30, 16'h1234);
    checks++; if (sel !== 1'b1 || wr !== 1'b0) begin errors++; $display("FAIL bp_read_issue: got sel=%b wr=%b want sel=1 wr=0", sel, wr); end
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      checks++; if (rsp_valid !== 1'b1)     begin errors++; $display("FAIL bp_hold%0d_valid: got %b want 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL bp_hold%0d_rdata: got %h want beef", i, rsp_rdata); end
      checks++; if (sel !== 1'b0)           begin errors++; $display("FAIL bp_hold%0d_sel: got %b want 0", i, sel); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_clear: got %b want 0", rsp_valid); end
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL bp_no_issue_at_handshake: got %b want 0", sel); end
    step();
    checks++; if (sel !== 1'b1)        begin errors++; $display("FAIL bp_next_sel: got %b want 1", sel); end
    checks++; if (addr !== 8'h30)      begin errors++; $display("FAIL bp_next_addr: got %h want 30", addr); end
    checks++; if (wdata !== 16'h1234)  begin errors++; $display("FAIL bp_next_wdata: got %h want 1234", wdata); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b want 0", busy); end
  endtask

  // ready low for 3 edges during a write to 0x10, then read back with
  // rsp_ready already high.
  task automatic test_ready_stall();
    ready     = 1'b0;
    rsp_ready = 1'b0;
    push(1'b1, 8'h10, 16'hA5A5);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sel !== 1'b1 || wr !== 1'b1 || addr !== 8'h10 || wdata !== 16'hA5A5) begin
        errors++;
        $display("FAIL stall%0d_hold: got sel=%b wr=%b addr=%h wdata=%h want 1 1 10 a5a5", i, sel, wr, addr, wdata);
      end
      step();
    end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL stall_before_release: got %b want 1", sel); end
    ready = 1'b1;
    step();
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL stall_accept: got %b want 0", sel); end

    rsp_ready = 1'b1;
    push(1'b0, 8'h10, 16'h0000);
    step();
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_rb_early: got %b want 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1)     begin errors++; $display("FAIL stall_rb_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_rdata !== 16'hA5A5) begin errors++; $display("FAIL stall_rb_rdata: got %h want a5a5", rsp_rdata); end
    step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_rb_one_cycle: got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  // Reset while a write is stalled in REQ with two more queued.
  task automatic test_reset_midflight();
    ready     = 1'b0;
    rsp_ready = 1'b0;
    push(1'b1, 8'h40, 16'h4444);
    push(1'b1, 8'h41, 16'h5555);
    push(1'b1, 8'h42, 16'h6666);
    checks++; if (sel !== 1'b1 || addr !== 8'h40) begin errors++; $display("FAIL mid_in_req: got sel=%b addr=%h want 1 40", sel, addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rstn = 1'b0;
    step();
    checks++; if (sel !== 1'b0)       begin errors++; $display("FAIL mid_rst_sel: got %b want 0", sel); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_valid: got %b want 0", rsp_valid); end
    rstn  = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (sel !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_after%0d: got sel=%b rsp_valid=%b busy=%b want 0 0 0", i, sel, rsp_valid, busy);
      end
    end
  endtask

`ifdef REG_CMD_MASTER_TIMEOUT_EN
  // Read with ready stuck low times out after 8 stalled cycles.
  task automatic test_timeout();
    ready     = 1'b0;
    rsp_ready = 1'b0;
    push(1'b0, 8'h50, 16'h0000);
    step();
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL to_sel_rise: got %b want 1", sel); end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || sel !== 1'b1) begin
        errors++; $display("FAIL to_wait%0d: got rsp_valid=%b sel=%b want 0 1", i, rsp_valid, sel);
      end
    end
    step();
    checks++; if (rsp_valid !== 1'b1)     begin errors++; $display("FAIL to_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_err !== 1'b1)       begin errors++; $display("FAIL to_rsp_err: got %b want 1", rsp_err); end
    checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL to_rsp_rdata: got %h want 0000", rsp_rdata); end
    checks++; if (sel !== 1'b0)           begin errors++; $display("FAIL to_sel: got %b want 0", sel); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    ready     = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_rsp_clear: got %b want 0", rsp_valid); end
  endtask
`endif

  initial begin
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 16'h0000;
    ready     = 1'b1;
    rsp_ready = 1'b0;

    test_reset();
    test_write_read();
    test_fifo_full();
    test_rsp_backpressure();
    test_ready_stall();
    test_reset_midflight();
`ifdef REG_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
